// File: rtl/spi_frame_pkg.sv
// Shared constants and types for the SPI register-write front-end.
// Field positions assume the fixed 16-bit rw/addr/data frame layout.
package spi_frame_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;

    localparam int RW_BIT   = 15;
    localparam int ADDR_MSB = 14;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

endpackage

// File: rtl/spi_frame_deserializer_sync.sv
// Pin synchroniser (SYNC_STAGES flops) plus history flop with rise/fall strobes.
// Latency: level is SYNC_STAGES cycles behind the pin; no backpressure.
// Edge strobes are combinational from the last sync stage and the history flop.
module sync_edge_detect #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_frame_deserializer.sv
// SPI mode-0 frame deserializer: shifts COPI into a 16-bit rw/addr/data frame.
// Latency: frame_valid/frame_err pulse SYNC_STAGES+2 clk cycles after nCS rises.
// Backpressure: none; the consumer must accept the one-cycle valid pulse.
module spi_frame_deserializer
    import spi_frame_pkg::*;
#(
    parameter int FRAME_BITS  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SCLK,
    input  logic              nCS,
    input  logic              COPI,
    output logic              frame_valid,
    output logic              frame_rw,
    output logic [ADDR_W-1:0] frame_addr,
    output logic [DATA_W-1:0] frame_data,
    output logic              frame_err,
    output logic              busy
);

    localparam int          SETTLE_W   = $clog2(SYNC_STAGES + 2);
    localparam logic [4:0]  CNT_FULL   = 5'(FRAME_BITS);
    localparam logic [4:0]  CNT_SAT    = 5'(FRAME_BITS + 1);

    logic sclk_level, sclk_rise, sclk_fall;
    logic ncs_level, ncs_rise, ncs_fall;
    logic copi_level, copi_rise, copi_fall;
    logic unused_edges;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst_n(rst_n), .pin(SCLK),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs_sync (
        .clk(clk), .rst_n(rst_n), .pin(nCS),
        .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_copi_sync (
        .clk(clk), .rst_n(rst_n), .pin(COPI),
        .level(copi_level), .rise(copi_rise), .fall(copi_fall)
    );

    assign unused_edges = ^{sclk_level, sclk_fall, copi_rise, copi_fall};

    // After reset the nCS synchroniser may see a fake 1->0 edge if the pin is
    // already low (reset mid-frame); ignore falls until the pipeline has flushed.
    logic [SETTLE_W-1:0] settle_cnt;
    logic                settled;

    assign settled = (settle_cnt == SETTLE_W'(SYNC_STAGES + 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
        end else if (!settled) begin
            settle_cnt <= settle_cnt + 1'b1;
        end
    end

    state_t state_q, state_d;
    logic   start, shift_en, close;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // nCS rise wins over a coincident SCLK rise, so that edge is never counted.
    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        shift_en = 1'b0;
        close    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ncs_fall && settled) begin
                    state_d = RECV;
                    start   = 1'b1;
                end
            end
            RECV: begin
                if (ncs_rise) begin
                    state_d = IDLE;
                    close   = 1'b1;
                end else if (sclk_rise && !ncs_level) begin
                    shift_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic [FRAME_BITS-1:0] shift_q;
    logic [4:0]            bit_cnt;
    logic                  close_good_q, close_bad_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q      <= '0;
            bit_cnt      <= '0;
            close_good_q <= 1'b0;
            close_bad_q  <= 1'b0;
            frame_valid  <= 1'b0;
            frame_err    <= 1'b0;
            frame_rw     <= 1'b0;
            frame_addr   <= '0;
            frame_data   <= '0;
        end else begin
            if (start) begin
                shift_q <= '0;
                bit_cnt <= '0;
            end else if (shift_en) begin
                shift_q <= {shift_q[FRAME_BITS-2:0], copi_level};
                if (bit_cnt != CNT_SAT) begin
                    bit_cnt <= bit_cnt + 5'd1;
                end
            end
            close_good_q <= close && (bit_cnt == CNT_FULL);
            close_bad_q  <= close && (bit_cnt != CNT_FULL);
            frame_valid  <= close_good_q;
            frame_err    <= close_bad_q;
            if (close_good_q) begin
                frame_rw   <= shift_q[RW_BIT];
                frame_addr <= shift_q[ADDR_MSB:ADDR_LSB];
                frame_data <= shift_q[DATA_MSB:0];
            end
        end
    end

    assign busy = (state_q == RECV);

endmodule

// File: tb/tb_spi_frame_deserializer.sv
// Directed bench for spi_frame_deserializer with a pin-level frame model and
// a per-cycle compare process, plus literal expectations after each scenario.
module tb_spi_frame_deserializer;

    localparam int SYNC_STAGES = 2;
    localparam int LAT         = SYNC_STAGES + 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SCLK = 1'b0;
    logic       nCS  = 1'b1;
    logic       COPI = 1'b0;
    logic       frame_valid, frame_rw, frame_err, busy;
    logic [6:0] frame_addr;
    logic [7:0] frame_data;

    spi_frame_deserializer #(.FRAME_BITS(16), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .nCS(nCS), .COPI(COPI),
        .frame_valid(frame_valid), .frame_rw(frame_rw), .frame_addr(frame_addr),
        .frame_data(frame_data), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;
    int last_valid_cyc = -1;
    int last_err_cyc   = -1;
    int last_rise_cyc  = -1;

    // Model: expected close events, scheduled by pin-level nCS rise time.
    typedef struct {
        int          due;
        bit          ok;
        logic [15:0] word;
    } ev_t;
    ev_t evq[$];

    bit          checking   = 1'b0;
    bit          m_in_frame = 1'b0;
    logic [15:0] m_word     = '0;
    int          m_n        = 0;
    logic        m_rw       = 1'b0;
    logic [6:0]  m_addr     = '0;
    logic [7:0]  m_data     = '0;
    logic [SYNC_STAGES:0] act_pipe;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) act_pipe <= '0;
        else        act_pipe <= {act_pipe[SYNC_STAGES-1:0], m_in_frame};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        bit  ev_v;
        bit  ev_e;
        ev_t e;
        if (checking) begin
            ev_v = 1'b0;
            ev_e = 1'b0;
            if (evq.size() > 0 && evq[0].due == cyc) begin
                e = evq.pop_front();
                if (e.ok) begin
                    ev_v   = 1'b1;
                    m_rw   = e.word[15];
                    m_addr = e.word[14:8];
                    m_data = e.word[7:0];
                end else begin
                    ev_e = 1'b1;
                end
            end
            check("cyc_valid", frame_valid, ev_v);
            check("cyc_err",   frame_err,   ev_e);
            check("cyc_rw",    frame_rw,    m_rw);
            check("cyc_addr",  frame_addr,  m_addr);
            check("cyc_data",  frame_data,  m_data);
            check("cyc_busy",  busy,        act_pipe[SYNC_STAGES]);
            if (frame_valid) begin valid_cnt++; last_valid_cyc = cyc; end
            if (frame_err)   begin err_cnt++;   last_err_cyc   = cyc; end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic cs_low();
        nCS        = 1'b0;
        m_in_frame = 1'b1;
        m_word     = '0;
        m_n        = 0;
        wait_clks(4);
    endtask

    task automatic push_close();
        ev_t e;
        if (m_in_frame) begin
            e.due  = cyc + LAT;
            e.ok   = (m_n == 16);
            e.word = m_word;
            evq.push_back(e);
        end
        m_in_frame    = 1'b0;
        last_rise_cyc = cyc;
    endtask

    task automatic cs_high();
        nCS = 1'b1;
        push_close();
        wait_clks(10);
    endtask

    task automatic send_bit(input logic b);
        COPI = b;
        wait_clks(4);
        SCLK = 1'b1;
        if (m_in_frame) begin
            m_word = {m_word[14:0], b};
            if (m_n < 100) m_n++;
        end
        wait_clks(4);
        SCLK = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] val, input int nbits);
        cs_low();
        for (int i = nbits - 1; i >= 0; i--) send_bit(val[i]);
        wait_clks(4);
        cs_high();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        evq.delete();
        m_in_frame = 1'b0;
        m_rw   = 1'b0;
        m_addr = '0;
        m_data = '0;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(6);
    endtask

    initial begin
        int v0, e0;
        logic [15:0] w;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        checking = 1'b1;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(6);
        check("rst_busy", busy, 0);
        check("rst_data", frame_data, 0);
        check("rst_addr", frame_addr, 0);

        // Write frame 0x80AA, with exact latency from the nCS pin rise
        send_frame(64'h80AA, 16);
        check("w1_valid_cnt", valid_cnt, 1);
        check("w1_err_cnt", err_cnt, 0);
        check("w1_latency", last_valid_cyc - last_rise_cyc, 4);
        check("w1_rw", frame_rw, 1);
        check("w1_addr", frame_addr, 7'h00);
        check("w1_data", frame_data, 8'hAA);

        // Back-to-back frames
        send_frame(64'h82F0, 16);
        check("b1_rw", frame_rw, 1);
        check("b1_addr", frame_addr, 7'h02);
        check("b1_data", frame_data, 8'hF0);
        send_frame(64'h0312, 16);
        check("b2_rw", frame_rw, 0);
        check("b2_addr", frame_addr, 7'h03);
        check("b2_data", frame_data, 8'h12);
        check("b2_valid_cnt", valid_cnt, 3);

        // Short, long and saturating frames
        send_frame(64'h00A5, 8);
        check("s8_err_cnt", err_cnt, 1);
        check("s8_data_kept", frame_data, 8'h12);
        send_frame(64'h1FFFF, 17);
        check("s17_err_cnt", err_cnt, 2);
        send_frame(64'hFF_0102_0304, 40);
        check("s40_err_cnt", err_cnt, 3);
        check("s40_valid_cnt", valid_cnt, 3);
        check("s40_addr_kept", frame_addr, 7'h03);
        check("s40_err_latency", last_err_cyc - last_rise_cyc, 4);

        // Reset mid-frame, then nCS released: no pulse at all
        v0 = valid_cnt; e0 = err_cnt;
        w = 16'hFFFF;
        cs_low();
        for (int i = 0; i < 9; i++) send_bit(w[i]);
        check("mid_busy", busy, 1);
        do_reset();
        wait_clks(4);
        cs_high();
        check("rstmid_valid_cnt", valid_cnt, v0);
        check("rstmid_err_cnt", err_cnt, e0);
        check("rstmid_data", frame_data, 0);
        check("rstmid_busy", busy, 0);
        send_frame(64'h84FF, 16);
        check("post_rst_rw", frame_rw, 1);
        check("post_rst_addr", frame_addr, 7'h04);
        check("post_rst_data", frame_data, 8'hFF);
        check("post_rst_valid_cnt", valid_cnt, v0 + 1);

        // 16th SCLK rise coincides with nCS rise: only 15 bits count
        v0 = valid_cnt; e0 = err_cnt;
        w = 16'h8555;
        cs_low();
        for (int i = 15; i >= 1; i--) send_bit(w[i]);
        COPI = w[0];
        wait_clks(4);
        SCLK = 1'b1;
        nCS  = 1'b1;
        push_close();
        wait_clks(4);
        SCLK = 1'b0;
        wait_clks(8);
        check("simul_err_cnt", err_cnt, e0 + 1);
        check("simul_valid_cnt", valid_cnt, v0);
        check("simul_data_kept", frame_data, 8'hFF);

        // SCLK toggling with nCS high is ignored
        e0 = err_cnt;
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        wait_clks(8);
        check("idle_sclk_err", err_cnt, e0);
        check("idle_sclk_valid", valid_cnt, v0);
        check("idle_sclk_busy", busy, 0);
        send_frame(64'h0000, 16);
        check("zero_frame_rw", frame_rw, 0);
        check("zero_frame_data", frame_data, 8'h00);
        check("evq_drained", evq.size(), 0);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_frame_deserializer.md
Name: spi_frame_deserializer

Overview:
Front-end for the SPI register-write path. Synchronises the raw SCLK/nCS/COPI pins into the clk domain, detects SCLK/nCS edges, and shifts COPI into a fixed 16-bit frame. On frame close it presents a decoded rw/addr/data transaction with a one-cycle valid pulse. The register file, which drives the PWM peripheral's enable and duty-cycle registers, consumes that transaction. SPI mode 0 only, MSB first, single clock domain after the synchroniser.

Parameters:
FRAME_BITS, 16, number of bits in a legal frame; fixed field layout below assumes 16
SYNC_STAGES, 2, flip-flops in each pin synchroniser (minimum 2)

Ports:
clk  input  1  system clock; the only clock
rst_n  input  1  asynchronous active-low reset
SCLK  input  1  raw SPI clock pin, asynchronous to clk
nCS  input  1  raw SPI chip select pin, active low, asynchronous
COPI  input  1  raw SPI data pin, asynchronous
frame_valid  output  1  one-cycle pulse: a legal frame closed and frame_* fields are updated
frame_rw  output  1  frame bit 15; 1 = write, 0 = read
frame_addr  output  7  frame bits 14:8
frame_data  output  8  frame bits 7:0
frame_err  output  1  one-cycle pulse: a frame closed with bit count != FRAME_BITS
busy  output  1  high while synchronised nCS is low

Behaviour:
- Reset (async assert, sync deassert by the clk domain): all synchroniser flops go to idle pin levels: SCLK 0, nCS 1, COPI 0. The shift register, bit counter, frame_valid, frame_err, frame_rw, frame_addr and frame_data all clear to 0. busy clears to 0.
- Synchroniser: SCLK, nCS and COPI each pass through SYNC_STAGES flops plus one history flop. All three share the same depth, so COPI stays aligned with the detected SCLK edge.
- Edges: sclk_rise = synced SCLK high while history low. ncs_fall and ncs_rise are defined the same way on nCS.
- State machine, two states:
  - IDLE: waits for ncs_fall. On ncs_fall, clear the bit counter and shift register, then go to RECV.
  - RECV:
    - On sclk_rise with synced nCS low: shift the synced COPI into the LSB and increment the counter. The counter is 5 bits and saturates at FRAME_BITS+1; it never wraps.
    - On ncs_rise: go to IDLE. If counter == FRAME_BITS, pulse frame_valid and load the frame_* fields from the shift register. Otherwise pulse frame_err and leave the frame_* fields unchanged.
- Simultaneous sclk_rise and ncs_rise in the same clk cycle: the SCLK edge is discarded, and the frame is judged on the count before that edge.
- SCLK edges while nCS is high are ignored. SCLK falling edges are ignored.
- Latency: frame_valid asserts SYNC_STAGES+2 clk cycles after the nCS pin rises. This is 4 cycles at default.
- frame_* hold their value until the next legal frame or reset. frame_valid and frame_err are never high together.
- Read frames (rw = 0) are still reported with frame_valid. The consumer decides whether to ignore them; this block does no address filtering.
- Reset mid-frame: the partial frame is discarded. No valid or err pulse is emitted, even when nCS later rises.
- Throughput requirement: SCLK high and low phases must each be at least SYNC_STAGES+1 clk periods. Behaviour is undefined for faster SCLK.

Decomposition:
- Shared package spi_frame_pkg holds:
  - FRAME_BITS, ADDR_W = 7, DATA_W = 8
  - field position constants: RW_BIT = 15, ADDR_MSB = 14, ADDR_LSB = 8, DATA_MSB = 7
  - state enum {IDLE, RECV}
- One natural sub-module, sync_edge_detect: SYNC_STAGES-deep synchroniser plus history flop, with rise/fall outputs. Instantiate it for SCLK and nCS. COPI uses the same module with its edge outputs unused.

Test Plan:
- Write frame: reset, then nCS low, clock 0x80AA MSB first, nCS high -> single frame_valid with rw=1, addr=0x00, data=0xAA, 4 cycles after nCS rises; frame_err stays 0.
- Back-to-back frames: 0x82F0 then 0x0312 -> two frame_valid pulses. First gives rw=1, addr=0x02, data=0xF0. Second gives rw=0, addr=0x03, data=0x12.
- Short frame (8 bits) -> one frame_err pulse, no frame_valid, frame_* keep their previous values. Repeat with 17 bits, and with 40 bits to exercise counter saturation -> same response.
- Reset mid-frame: assert rst_n low after 9 bits, release, then raise nCS -> no valid or err pulse and all outputs 0. A following legal 0x84FF frame -> valid with addr=0x04, data=0xFF.
- Simultaneous edges: drive the final (16th) SCLK rise in the same synchronised cycle as the nCS rise -> frame_err, since only 15 bits are counted. Separately, toggle SCLK while nCS is high -> no counter change and no pulses.
- busy tracks synchronised nCS with a lag of SYNC_STAGES+1 cycles; it is 0 out of reset and 1 throughout RECV.
